// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART handshake bundle for uart_tx_arbiter.
// master = requesters plus UART status side, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   reqValid;
  logic [NUM_REQ-1:0]   reqLast;
  logic [8*NUM_REQ-1:0] reqByte;
  logic [NUM_REQ-1:0]   reqReady;
  logic [NUM_REQ-1:0]   grant;
  logic                 txEn;
  logic                 txStart;
  logic [7:0]           txByte;
  logic                 txBusy;
  logic                 txDone;
  logic                 arbBusy;

  modport master (
    output reqValid, reqLast, reqByte, txBusy, txDone,
    input  reqReady, grant, txEn, txStart, txByte, arbBusy
  );

  modport slave (
    input  reqValid, reqLast, reqByte, txBusy, txDone,
    output reqReady, grant, txEn, txStart, txByte, arbBusy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one Uart8 transmitter among NUM_REQ byte streams.
// Define UART_ARB_BURST_EN to hold the grant until a byte flagged reqLast completes.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rstN,
  uart_tx_arbiter_if.slave   bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef UART_ARB_BURST_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           txByte_q, txByte_d;
  logic                 lastFlag_q, lastFlag_d;
  logic                 txEn_q;

  logic                 locked;
  logic [NUM_REQ-1:0]   elig;
  logic                 found;
  logic [PW-1:0]        win;
  logic [PW-1:0]        cand;
  logic [NUM_REQ-1:0]   winOneHot;

  // A grant still held while idle can only mean a burst lock.
  assign locked    = LOCK_EN && (|grant_q);
  assign elig      = locked ? (bus.reqValid & grant_q) : bus.reqValid;
  assign winOneHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;

  // Scan upward from ptr+1; the first eligible requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(NUM_REQ-1);
      grant_q    <= '0;
      txByte_q   <= 8'h00;
      lastFlag_q <= 1'b0;
      txEn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      txByte_q   <= txByte_d;
      lastFlag_q <= lastFlag_d;
      txEn_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    txByte_d   = txByte_q;
    lastFlag_d = lastFlag_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          txByte_d   = bus.reqByte[{win, 3'b000} +: 8];
          grant_d    = winOneHot;
          ptr_d      = win;
          lastFlag_d = bus.reqLast[win];
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!bus.txBusy) state_d = S_SEND;
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        // txBusy is deliberately ignored here; only txDone ends the frame.
        if (bus.txDone) begin
          state_d = S_IDLE;
          if (!(LOCK_EN && !lastFlag_q)) grant_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.reqReady = (rstN && state_q == S_IDLE && found) ? winOneHot : '0;
    bus.txStart  = (state_q == S_SEND);
    bus.grant    = grant_q;
    bus.txByte   = txByte_q;
    bus.txEn     = txEn_q;
    bus.arbBusy  = (state_q != S_IDLE) || (|grant_q);
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin transmit scheduler that shares one `Uart8` transmitter among `NUM_REQ` byte-stream requesters. It sits between the requesters and the `Uart8` tx interface. It accepts one byte per handshake, waits for the UART to be idle, issues a single-cycle start, and holds the UART until it reports completion. Optional burst locking keeps a requester granted until its last byte, so multi-byte messages are never interleaved.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).

Ports:
- `clk`  in  1  system clock.
- `rstN`  in  1  asynchronous, active-low reset.
- `reqValid`  in  NUM_REQ  requester i has a byte on `reqByte[8*i+:8]`.
- `reqLast`  in  NUM_REQ  the byte presented by requester i is the last of its message.
- `reqByte`  in  8*NUM_REQ  packed data bytes.
- `reqReady`  out  NUM_REQ  combinational accept; one-hot or zero; the byte is taken at the clock edge ending this cycle.
- `grant`  out  NUM_REQ  one-hot current owner; zero when idle.
- `txEn`  out  1  UART transmit enable.
- `txStart`  out  1  one-cycle start pulse to the UART.
- `txByte`  out  8  byte to transmit; stable from capture until `txDone`.
- `txBusy`  in  1  UART is transmitting.
- `txDone`  in  1  one-cycle UART completion pulse.
- `arbBusy`  out  1  state is not IDLE or a grant is held.

## Operation

- States: IDLE, LOAD, SEND, WAIT.
- IDLE, no lock: the eligible set is `reqValid`. The winner is the first set bit scanning upward from `ptr+1`, modulo NUM_REQ.
  - `reqReady[win]=1` combinationally.
  - At the edge: `txByte<=reqByte[win]`, `grant<=onehot(win)`, `ptr<=win`, `lastFlag<=reqLast[win]`, go to LOAD.
- IDLE, locked (burst only): only the `grant` owner is eligible. Other requesters are ignored.
- LOAD: wait while `txBusy=1`. When `txBusy=0`, go to SEND.
- SEND: `txStart=1` for exactly one cycle, then go to WAIT.
- WAIT: hold until `txDone=1`. Ignore `txBusy` during WAIT, so it is allowed to rise late. On `txDone`:
  - Without lock, or with `lastFlag=1`: clear `grant`, go to IDLE.
  - With lock and `lastFlag=0`: keep `grant`, go to IDLE (locked).
- `reqValid` dropping without a handshake is legal and has no effect.
- A `reqReady` pulse occurs only in IDLE.
- `txEn=1` in every cycle after reset release.
- Reset values: `grant=0`, `txStart=0`, `txByte=8'h00`, `txEn=0`, `arbBusy=0`, `reqReady=0`, `lastFlag=0`, `ptr=NUM_REQ-1` (requester 0 wins first), state IDLE.
- Reset asserted mid-transfer clears all of the above immediately (asynchronously). No `txStart` is re-issued after release.

## Timing

- Request seen in IDLE at cycle N:
  - `reqReady` high in cycle N.
  - `grant` and `txByte` valid from cycle N+1 (LOAD).
  - `txStart` in cycle N+2 when `txBusy=0` at N+1.
- Each cycle of `txBusy=1` in LOAD adds one cycle of delay.
- `txDone` in cycle M: back in IDLE at M+1. The next `reqReady` can occur at M+1, giving a minimum inter-byte gap of 3 cycles plus the UART frame.
- `txDone` arriving in LOAD or SEND is a protocol violation and is ignored.
- Simultaneous requests resolve within the same cycle using `ptr`. No starvation: the worst-case wait is NUM_REQ-1 messages.

## Configuration

- `UART_ARB_BURST_EN` defined:
  - The grant locks until a byte with `reqLast=1` completes.
  - A locked owner with `reqValid=0` stalls the arbiter indefinitely, with `grant` and `arbBusy` held high.
- `UART_ARB_BURST_EN` undefined:
  - Every byte is arbitrated independently and `reqLast` is ignored.
  - `grant` clears after every `txDone`.

## Test plan

- Reset, then requester 0 presents 0xD6 for one handshake: `reqReady=0001` for one cycle, then `grant=0001`, `txByte=0xD6`, one `txStart` two cycles after the request. Drive `txDone`: `grant=0000`.
- Requesters 0 and 2 are valid together and both re-request immediately after each accept: service order 0, 2, 0, 2, with `txByte` matching each requester's byte.
- `txBusy` held high for 5 cycles after capture: `txStart` is issued exactly 1 cycle after `txBusy` falls, and only once.
- Burst on: requester 1 sends 0x11, 0x22, 0x33 (last on 0x33) while requester 3 holds 0xA5 valid. UART bytes are 0x11, 0x22, 0x33, then 0xA5. Repeat with the macro off: bytes are 0x11, 0xA5, 0x22, 0x33 (requester 3 drops `reqValid` after its accept).
- Assert `rstN` low in WAIT: all outputs read zero in the same timestep. After release, a request from requester 2 alone is granted; a request from 0 and 2 together is granted to 0.
- Burst on: the locked owner drops `reqValid` for 20 cycles with `lastFlag=0`. `grant` and `arbBusy` stay high, other requesters get no `reqReady`, and the owner resumes normally.
